lm96570_spi_ctrl: RTL and testbench

//  Avalon-MM slave that serialises a software-written config word into the LM96570 pulser serial port.

---
 rtl/lm96570_spi_pkg.sv | 25 ++
 rtl/lm96570_spi_shifter.sv | 60 ++++++
 rtl/lm96570_spi_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lm96570_spi_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lm96570_spi_pkg.sv
// Shared definitions for the LM96570 serial-port controller: register map, field indices, FSM states.
package lm96570_spi_pkg;

    localparam logic [1:0] AddrTxdata = 2'd0;
    localparam logic [1:0] AddrCtrl   = 2'd1;
    localparam logic [1:0] AddrGo     = 2'd2;
    localparam logic [1:0] AddrRxdata = 2'd3;

    localparam int unsigned CtrlLsbFirst = 8;
    localparam int unsigned CtrlIrqEn    = 9;

    localparam int unsigned GoStart   = 0;
    localparam int unsigned GoClear   = 1;
    localparam int unsigned StatBusy  = 0;
    localparam int unsigned StatDone  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLow,
        StHigh,
        StLatch,
        StGap
    } spi_state_e;

endpackage

// File: rtl/lm96570_spi_shifter.sv
// TX/RX shift registers for the LM96570 frame; direction chosen by lsb_first, frame MSB at top_idx.
module lm96570_spi_shifter
    import lm96570_spi_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic              sample,
    input  logic              lsb_first,
    input  logic [IDX_W-1:0]  top_idx,
    input  logic [DATA_W-1:0] load_data,
    input  logic              sdo,
    output logic              sdi,
    output logic [DATA_W-1:0] rx_data
);

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load) begin
            tx_d = load_data;
            rx_d = '0;
        end else begin
            if (shift) begin
                tx_d = lsb_first ? (tx_q >> 1) : (tx_q << 1);
            end
            // RX enters at the end TX leaves, so RXDATA[N-1:0] ends up in transmit order.
            if (sample) begin
                if (lsb_first) begin
                    rx_d          = rx_q >> 1;
                    rx_d[top_idx] = sdo;
                end else begin
                    rx_d    = rx_q << 1;
                    rx_d[0] = sdo;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

    assign sdi     = lsb_first ? tx_q[0] : tx_q[top_idx];
    assign rx_data = rx_q;

endmodule

// File: rtl/lm96570_spi_ctrl.sv
// Avalon-MM slave that serialises a config word to the LM96570 serial port (SCLK/SDI/LE, SDO capture).
module lm96570_spi_ctrl
    import lm96570_spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SCLK_HALF = 4,
    parameter int unsigned LE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              spi_sclk,
    output logic              spi_sdi,
    output logic              spi_le,
    input  logic              spi_sdo,
    output logic              busy_irq
);

    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned MAX_T = (SCLK_HALF > LE_CYCLES) ? SCLK_HALF : LE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_T);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] txdata_q;
    logic [9:0]        ctrl_q;
    logic              done_q;

    logic              wr, go, busy, half_end, le_end;
    logic              load, shift, sample, set_done;
    logic [IDX_W-1:0]  top_idx;
    logic              sh_sdi;
    logic [DATA_W-1:0] rx_data;
    logic              unused_wdata;

    assign wr   = chipselect & ~write_n;
    assign go   = wr && (address == AddrGo) && writedata[GoStart];
    assign busy = (state_q != StIdle);

    assign half_end = (cnt_q == CNT_W'(SCLK_HALF - 1));
    assign le_end   = (cnt_q == CNT_W'(LE_CYCLES - 1));

    // Clamp oversize nbits fields to the shift register width.
    always_comb begin
        if (ctrl_q[5:0] > 6'(DATA_W - 1)) begin
            top_idx = IDX_W'(DATA_W - 1);
        end else begin
            top_idx = ctrl_q[IDX_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bitcnt_d = bitcnt_q;
        load     = 1'b0;
        shift    = 1'b0;
        sample   = 1'b0;
        set_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (go) begin
                    load     = 1'b1;
                    bitcnt_d = top_idx;
                    state_d  = StLow;
                end
            end
            StLow: begin
                if (half_end) begin
                    cnt_d   = '0;
                    sample  = 1'b1;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (bitcnt_q == '0) begin
                        state_d = StLatch;
                    end else begin
                        shift    = 1'b1;
                        bitcnt_d = bitcnt_q - 1'b1;
                        state_d  = StLow;
                    end
                end
            end
            StLatch: begin
                if (le_end) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (half_end) begin
                    cnt_d    = '0;
                    set_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            txdata_q <= '0;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            if (wr && (address == AddrTxdata)) begin
                txdata_q <= writedata;
            end
            if (wr && (address == AddrCtrl) && !busy) begin
                ctrl_q <= {writedata[CtrlIrqEn], writedata[CtrlLsbFirst], 2'b00, writedata[5:0]};
            end
            if (set_done) begin
                done_q <= 1'b1;
            end else if (wr && (address == AddrGo) && writedata[GoClear]) begin
                done_q <= 1'b0;
            end
        end
    end

    lm96570_spi_shifter #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .shift     (shift),
        .sample    (sample),
        .lsb_first (ctrl_q[CtrlLsbFirst]),
        .top_idx   (top_idx),
        .load_data (txdata_q),
        .sdo       (spi_sdo),
        .sdi       (sh_sdi),
        .rx_data   (rx_data)
    );

    always_comb begin
        readdata = '0;
        unique case (address)
            AddrTxdata: readdata = txdata_q;
            AddrCtrl:   readdata = DATA_W'(ctrl_q);
            AddrGo: begin
                readdata[StatDone] = done_q;
                readdata[StatBusy] = busy;
            end
            AddrRxdata: readdata = rx_data;
            default:    readdata = '0;
        endcase
    end

    assign spi_sclk = (state_q == StHigh);
    assign spi_le   = (state_q == StLatch);
    assign spi_sdi  = ((state_q == StLow) || (state_q == StHigh)) ? sh_sdi : 1'b0;
    assign busy_irq = done_q & ctrl_q[CtrlIrqEn];

    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_lm96570_spi_ctrl.sv
// Directed self-checking bench for lm96570_spi_ctrl: frames, bit order, loopback, busy rules, reset abort.
module tb_lm96570_spi_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        spi_sclk, spi_sdi, spi_le, spi_sdo, busy_irq;
    logic        loop_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd, bits;
    int          edges, busy_cyc, le_cyc, sdi_bad;
    logic [1:0]  first_stat;

    assign spi_sdo = loop_en ? spi_sdi : 1'b0;

    always #5 clk = ~clk;

    lm96570_spi_ctrl #(
        .DATA_W    (32),
        .SCLK_HALF (4),
        .LE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .spi_sclk   (spi_sclk),
        .spi_sdi    (spi_sdi),
        .spi_le     (spi_le),
        .spi_sdo    (spi_sdo),
        .busy_irq   (busy_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd2;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Issue GO, then watch pins once per cycle until STATUS.busy drops; optional mid-frame writes.
    task automatic run_frame(input logic [31:0] go_data,
                             input int inj0_at, input logic [1:0] inj0_addr, input logic [31:0] inj0_data,
                             input int inj1_at, input logic [1:0] inj1_addr, input logic [31:0] inj1_data,
                             output logic [31:0] o_bits, output int o_edges, output int o_busy,
                             output int o_le, output logic [1:0] o_first, output int o_bad);
        logic prev_sclk, prev_sdi;
        o_bits = '0; o_edges = 0; o_busy = 0; o_le = 0; o_first = 2'b00; o_bad = 0;
        prev_sclk = 1'b0;
        prev_sdi  = 1'b0;
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = go_data;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            chipselect = 1'b0;
            write_n    = 1'b1;
            address    = 2'd2;
            writedata  = '0;
            #1;
            if (cyc == 0) o_first = readdata[1:0];
            if (readdata[0] !== 1'b1) break;
            o_busy++;
            if (spi_le) o_le++;
            if (spi_sclk && !prev_sclk) begin
                o_edges++;
                o_bits = {o_bits[30:0], spi_sdi};
            end
            if (spi_sclk && prev_sclk && (spi_sdi !== prev_sdi)) o_bad++;
            prev_sclk = spi_sclk;
            prev_sdi  = spi_sdi;
            if (cyc == inj0_at) begin
                chipselect = 1'b1; write_n = 1'b0; address = inj0_addr; writedata = inj0_data;
            end else if (cyc == inj1_at) begin
                chipselect = 1'b1; write_n = 1'b0; address = inj1_addr; writedata = inj1_data;
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        loop_en    = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            chk($sformatf("reset_reg%0d", a), rd, 32'h0);
        end
        chk("reset_sclk", {31'b0, spi_sclk}, 32'h0);
        chk("reset_le", {31'b0, spi_le}, 32'h0);
        chk("reset_sdi", {31'b0, spi_sdi}, 32'h0);
        chk("reset_irq", {31'b0, busy_irq}, 32'h0);

        // 8-bit MSB-first frame
        bus_write(2'd0, 32'hA5);
        bus_write(2'd1, 32'h7);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("msb_bits", bits, 32'hA5);
        chk("msb_edges", edges, 8);
        chk("msb_busy_len", busy_cyc, 72);
        chk("msb_le_len", le_cyc, 4);
        chk("msb_sdi_stable", sdi_bad, 0);
        chk("msb_first_stat", {30'b0, first_stat}, 32'h1);
        bus_read(2'd2, rd);
        chk("msb_done", rd, 32'h2);
        bus_read(2'd3, rd);
        chk("msb_rx", rd, 32'hA5);
        chk("msb_irq_off", {31'b0, busy_irq}, 32'h0);

        // LSB-first frames with SDO looped back
        bus_write(2'd1, 32'h107);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("lsb_bits", bits, 32'hA5);
        chk("lsb_busy_len", busy_cyc, 72);
        chk("lsb_first_stat", {30'b0, first_stat}, 32'h3);
        bus_read(2'd3, rd);
        chk("lsb_rx", rd, 32'hA5);
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'h103);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("lsb4_bits", bits, 32'h8);
        chk("lsb4_edges", edges, 4);
        chk("lsb4_busy_len", busy_cyc, 40);
        bus_read(2'd3, rd);
        chk("lsb4_rx", rd, 32'h1);
        bus_write(2'd1, 32'h3);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("msb4_bits", bits, 32'h1);
        bus_read(2'd3, rd);
        chk("msb4_rx", rd, 32'h1);

        // GO and TXDATA writes during a frame
        bus_write(2'd0, 32'hA5);
        bus_write(2'd1, 32'h7);
        run_frame(32'h1, 10, 2'd2, 32'h1, 20, 2'd0, 32'hFF,
                  bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("busy_go_bits", bits, 32'hA5);
        chk("busy_go_len", busy_cyc, 72);
        bus_read(2'd0, rd);
        chk("busy_txdata_taken", rd, 32'hFF);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("next_go_bits", bits, 32'hFF);

        // 32-bit frame, CTRL write while busy, done clear, irq gating
        bus_write(2'd0, 32'h8000_0001);
        bus_write(2'd1, 32'h21F);
        run_frame(32'h1, 50, 2'd1, 32'h0, -1, 2'd0, 0,
                  bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("w32_bits", bits, 32'h8000_0001);
        chk("w32_edges", edges, 32);
        chk("w32_busy_len", busy_cyc, 264);
        bus_read(2'd3, rd);
        chk("w32_rx", rd, 32'h8000_0001);
        bus_read(2'd1, rd);
        chk("ctrl_busy_ignored", rd, 32'h21F);
        chk("irq_on", {31'b0, busy_irq}, 32'h1);
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, rd);
        chk("done_cleared", rd, 32'h0);
        chk("irq_cleared", {31'b0, busy_irq}, 32'h0);
        bus_write(2'd1, 32'h01F);
        bus_write(2'd0, 32'h3);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("w32b_bits", bits, 32'h3);
        bus_read(2'd2, rd);
        chk("w32b_done", rd, 32'h2);
        chk("irq_masked", {31'b0, busy_irq}, 32'h0);
        run_frame(32'h3, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("start_clear_stat", {30'b0, first_stat}, 32'h1);
        chk("start_clear_bits", bits, 32'h3);

        // Asynchronous reset in the HIGH phase of bit 3
        bus_write(2'd0, 32'hC3);
        bus_write(2'd1, 32'h7);
        bus_write(2'd2, 32'h1);
        repeat (29) @(negedge clk);
        #1;
        chk("pre_reset_sclk", {31'b0, spi_sclk}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_sclk", {31'b0, spi_sclk}, 32'h0);
        chk("abort_le", {31'b0, spi_le}, 32'h0);
        bus_read(2'd2, rd);
        chk("abort_busy", rd, 32'h0);
        bus_read(2'd0, rd);
        chk("abort_txdata", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_write(2'd0, 32'h5A);
        bus_write(2'd1, 32'h7);
        run_frame(32'h1, -1, 2'd0, 0, -1, 2'd0, 0, bits, edges, busy_cyc, le_cyc, first_stat, sdi_bad);
        chk("post_reset_bits", bits, 32'h5A);
        chk("post_reset_edges", edges, 8);
        chk("post_reset_len", busy_cyc, 72);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
